// File: rtl/fp_pkg.sv
// Shared FP16/FP32 field layouts, exponent constants and unpack FSM state type.
// Used by fp16_to_fp32_unpack and its converter.
package fp_pkg;

    localparam int unsigned FP16_EXP_BIAS   = 15;
    localparam int unsigned FP32_EXP_BIAS   = 127;
    localparam logic [31:0] FP32_CANON_QNAN = 32'h7FC0_0000;

    // Rebias for normal FP16 values.
    localparam int unsigned EXP_REBIAS    = FP32_EXP_BIAS - FP16_EXP_BIAS;
    // Subnormal with leading one at bit p lands at exponent p + SUBN_EXP_BASE.
    localparam int unsigned SUBN_EXP_BASE = EXP_REBIAS - 9;

    typedef struct packed {
        logic       sign;
        logic [4:0] exp;
        logic [9:0] man;
    } fp16_t;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } fp32_t;

    typedef enum logic [1:0] {
        EMPTY,
        FIRST,
        SECOND,
        PASS
    } unpack_state_e;

    function automatic logic [3:0] lead_one(input logic [9:0] m);
        logic [3:0] p;
        p = '0;
        for (int i = 0; i < 10; i++) begin
            if (m[i]) p = 4'(i);
        end
        return p;
    endfunction

endpackage

// File: rtl/fp16_to_fp32_conv.sv
// Exact combinational FP16 -> FP32 widening with signalling-NaN and flush flags.
// FP16_TO_FP32_FTZ_EN flushes subnormal inputs to signed zero instead of normalising.
module fp16_to_fp32_conv
    import fp_pkg::*;
#(
    parameter bit CANON_NAN = 1'b0
) (
    input  fp16_t fp16_i,
    output fp32_t fp32_o,
    output logic  nv_o,
    output logic  uf_o
);

`ifndef FP16_TO_FP32_FTZ_EN
    logic [3:0] lead;
    logic [9:0] norm_man;

    assign lead     = lead_one(fp16_i.man);
    // Shifting the leading one to bit 10 drops it off the 10-bit result: the hidden bit.
    assign norm_man = fp16_i.man << (4'd10 - lead);
`endif

    always_comb begin
        fp32_o      = '0;
        nv_o        = 1'b0;
        uf_o        = 1'b0;
        fp32_o.sign = fp16_i.sign;

        if (fp16_i.exp == 5'd31) begin
            fp32_o.exp = 8'hFF;
            if (fp16_i.man != '0) begin
                nv_o = ~fp16_i.man[9];
                if (CANON_NAN) begin
                    fp32_o = FP32_CANON_QNAN;
                end else begin
                    fp32_o.man = {1'b1, fp16_i.man[8:0], 13'd0};
                end
            end
        end else if (fp16_i.exp != 5'd0) begin
            fp32_o.exp = {3'b000, fp16_i.exp} + 8'(EXP_REBIAS);
            fp32_o.man = {fp16_i.man, 13'd0};
        end else if (fp16_i.man != '0) begin
`ifdef FP16_TO_FP32_FTZ_EN
            uf_o = 1'b1;
`else
            fp32_o.exp = {4'b0000, lead} + 8'(SUBN_EXP_BASE);
            fp32_o.man = {norm_man, 13'd0};
`endif
        end
    end

endmodule

// File: rtl/fp16_to_fp32_unpack.sv
// Streaming unpacker: one FP32 word or a packed FP16 pair in, FP32 beats out.
// Build with FP16_TO_FP32_FTZ_EN to flush FP16 subnormals (out_uf then reports it).
module fp16_to_fp32_unpack
    import fp_pkg::*;
#(
    parameter bit CANON_NAN = 1'b0,
    parameter bit HI_FIRST  = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        out_nv,
    output logic        out_uf
);

    unpack_state_e state_q, state_d;
    logic [31:0]   word_q, word_d;
    logic          accept;
    logic          sel_hi;
    fp16_t         half;
    fp32_t         conv_data;
    logic          conv_nv;
    logic          conv_uf;

    always_comb begin
        in_ready = (state_q == EMPTY) |
                   (out_ready & ((state_q == SECOND) | (state_q == PASS)));
        accept   = in_valid & in_ready;
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = in_mode ? PASS : FIRST;
                    word_d  = in_data;
                end
            end
            FIRST: begin
                if (out_ready) state_d = SECOND;
            end
            SECOND, PASS: begin
                if (accept) begin
                    state_d = in_mode ? PASS : FIRST;
                    word_d  = in_data;
                end else if (out_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
        end
    end

    // Halves come straight from the held word, so beats stay stable under backpressure.
    always_comb begin
        sel_hi = (state_q == FIRST) ? HI_FIRST : !HI_FIRST;
        half   = sel_hi ? word_q[31:16] : word_q[15:0];
    end

    fp16_to_fp32_conv #(
        .CANON_NAN (CANON_NAN)
    ) u_conv (
        .fp16_i (half),
        .fp32_o (conv_data),
        .nv_o   (conv_nv),
        .uf_o   (conv_uf)
    );

    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        out_nv    = 1'b0;
        out_uf    = 1'b0;
        unique case (state_q)
            EMPTY: ;
            FIRST, SECOND: begin
                out_valid = 1'b1;
                out_data  = conv_data;
                out_last  = (state_q == SECOND);
                out_nv    = conv_nv;
                out_uf    = conv_uf;
            end
            PASS: begin
                out_valid = 1'b1;
                out_data  = word_q;
                out_last  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fp16_to_fp32_unpack.sv
// Bench for fp16_to_fp32_unpack: default instance plus a CANON_NAN=1/HI_FIRST=1 instance.
module tb_fp16_to_fp32_unpack;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_mode;
    logic        out_ready;

    logic        o0_in_ready, o0_valid, o0_last, o0_nv, o0_uf;
    logic [31:0] o0_data;
    logic        o1_in_ready, o1_valid, o1_last, o1_nv, o1_uf;
    logic [31:0] o1_data;

    int errors = 0;
    int checks = 0;

    fp16_to_fp32_unpack dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (o0_in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (o0_valid),
        .out_ready (out_ready),
        .out_data  (o0_data),
        .out_last  (o0_last),
        .out_nv    (o0_nv),
        .out_uf    (o0_uf)
    );

    fp16_to_fp32_unpack #(
        .CANON_NAN (1'b1),
        .HI_FIRST  (1'b1)
    ) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (o1_in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (o1_valid),
        .out_ready (out_ready),
        .out_data  (o1_data),
        .out_last  (o1_last),
        .out_nv    (o1_nv),
        .out_uf    (o1_uf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: value-level widening. Returns {data, nv, uf}.
    function automatic logic [33:0] ref_half(input logic [15:0] h, input bit canon);
        logic       s;
        int         e, m, sig, ex;
        logic [7:0] e32;
        logic [22:0] f32;
        s = h[15];
        e = int'(h[14:10]);
        m = int'(h[9:0]);
        if (e == 31) begin
            if (m == 0) return {s, 8'hFF, 23'd0, 2'b00};
            if (canon) return {32'h7FC0_0000, ~h[9], 1'b0};
            return {s, 8'hFF, 1'b1, h[8:0], 13'd0, ~h[9], 1'b0};
        end
        if (e == 0 && m == 0) return {s, 31'd0, 2'b00};
`ifdef FP16_TO_FP32_FTZ_EN
        if (e == 0) return {s, 31'd0, 2'b01};
`endif
        sig = (e == 0) ? m : m + 1024;
        ex  = (e == 0) ? -14 : e - 15;
        while (sig < 1024) begin
            sig = sig * 2;
            ex  = ex - 1;
        end
        e32 = 8'(ex + 127);
        f32 = 23'((sig - 1024) * 8192);
        return {s, e32, f32, 2'b00};
    endfunction

    function automatic logic [15:0] rand_half();
        logic [15:0] h;
        h = 16'($urandom);
        case ($urandom_range(0, 3))
            0:       h[14:10] = 5'd0;
            1:       h[14:10] = 5'd31;
            default: ;
        endcase
        return h;
    endfunction

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({o0_valid, o0_data, o0_last, o0_nv, o0_uf} !== 36'd0) begin
            errors++;
            $display("FAIL reset_outputs0: got v=%b d=%h l=%b nv=%b uf=%b, want all 0",
                     o0_valid, o0_data, o0_last, o0_nv, o0_uf);
        end
        checks++;
        if ({o1_valid, o1_data} !== 33'd0 || o0_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs1: got v=%b d=%h rdy=%b, want 0 0 1",
                     o1_valid, o1_data, o0_in_ready);
        end
        #2 rst_n = 1'b1;
    endtask

    task automatic test_packed();
        logic [31:0] w [3];
        logic [31:0] e0 [3];
        logic [31:0] e1 [3];
        logic [1:0]  f0 [3];
        logic [1:0]  f1 [3];
        logic [33:0] r;
        w[0] = 32'hC000_3C00; e0[0] = 32'h3F80_0000; e1[0] = 32'hC000_0000;
        f0[0] = 2'b00; f1[0] = 2'b00;
`ifdef FP16_TO_FP32_FTZ_EN
        w[1] = 32'h03FF_0001; e0[1] = 32'h0000_0000; e1[1] = 32'h0000_0000;
        f0[1] = 2'b01; f1[1] = 2'b01;
`else
        w[1] = 32'h03FF_0001; e0[1] = 32'h3380_0000; e1[1] = 32'h387F_C000;
        f0[1] = 2'b00; f1[1] = 2'b00;
`endif
        w[2] = 32'h7E00_7C01; e0[2] = 32'h7FC0_2000; e1[2] = 32'h7FC0_0000;
        f0[2] = 2'b10; f1[2] = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_data = w[i]; in_mode = 1'b0; out_ready = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            checks++;
            if ({o0_valid, o0_data, o0_last, o0_nv, o0_uf, o0_in_ready} !==
                {1'b1, e0[i], 1'b0, f0[i], 1'b0}) begin
                errors++;
                $display("FAIL packed%0d_first: got v=%b d=%h l=%b nv=%b uf=%b rdy=%b, want d=%h l=0 flags=%b rdy=0",
                         i, o0_valid, o0_data, o0_last, o0_nv, o0_uf, o0_in_ready, e0[i], f0[i]);
            end
            r = ref_half(w[i][31:16], 1'b1);
            checks++;
            if ({o1_data, o1_nv, o1_uf, o1_last} !== {r, 1'b0}) begin
                errors++;
                $display("FAIL packed%0d_first_canon: got d=%h nv=%b uf=%b l=%b, want %h %b",
                         i, o1_data, o1_nv, o1_uf, o1_last, r[33:2], r[1:0]);
            end
            @(negedge clk);
            checks++;
            if ({o0_valid, o0_data, o0_last, o0_nv, o0_uf} !== {1'b1, e1[i], 1'b1, f1[i]}) begin
                errors++;
                $display("FAIL packed%0d_second: got v=%b d=%h l=%b nv=%b uf=%b, want d=%h l=1 flags=%b",
                         i, o0_valid, o0_data, o0_last, o0_nv, o0_uf, e1[i], f1[i]);
            end
            r = ref_half(w[i][15:0], 1'b1);
            checks++;
            if ({o1_data, o1_nv, o1_uf, o1_last} !== {r, 1'b1}) begin
                errors++;
                $display("FAIL packed%0d_second_canon: got d=%h nv=%b uf=%b l=%b, want %h %b",
                         i, o1_data, o1_nv, o1_uf, o1_last, r[33:2], r[1:0]);
            end
            @(negedge clk);
            checks++;
            if (o0_valid !== 1'b0 || o1_valid !== 1'b0) begin
                errors++;
                $display("FAIL packed%0d_idle: got v0=%b v1=%b, want 0", i, o0_valid, o1_valid);
            end
        end
    endtask

    task automatic test_stall();
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 32'h7BFF_7C00; in_mode = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({o0_valid, o0_data, o0_last, o0_in_ready} !== {1'b1, 32'h7F80_0000, 2'b00}) begin
                errors++;
                $display("FAIL stall%0d: got v=%b d=%h l=%b rdy=%b, want 1 7f800000 0 0",
                         i, o0_valid, o0_data, o0_last, o0_in_ready);
            end
        end
        #1 out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({o0_valid, o0_data, o0_last} !== {1'b1, 32'h477F_E000, 1'b1}) begin
            errors++;
            $display("FAIL stall_second: got v=%b d=%h l=%b, want 1 477fe000 1",
                     o0_valid, o0_data, o0_last);
        end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 32'h1234_5678; in_mode = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_data = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++;
        if ({o0_valid, o0_data, o0_last, o0_nv, o0_in_ready, o1_data} !==
            {1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b1, 32'h1234_5678}) begin
            errors++;
            $display("FAIL pass_a: got v=%b d=%h l=%b nv=%b rdy=%b d1=%h, want 1 12345678 1 0 1",
                     o0_valid, o0_data, o0_last, o0_nv, o0_in_ready, o1_data);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({o0_valid, o0_data, o0_last, o0_nv, o1_data} !==
            {1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF}) begin
            errors++;
            $display("FAIL pass_b: got v=%b d=%h l=%b nv=%b d1=%h, want 1 ffffffff 1 0",
                     o0_valid, o0_data, o0_last, o0_nv, o1_data);
        end
        @(negedge clk);
        checks++;
        if (o0_valid !== 1'b0) begin
            errors++;
            $display("FAIL pass_idle: got v=%b, want 0", o0_valid);
        end
    endtask

    task automatic test_reset_mid_word();
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 32'h4400_4200; in_mode = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o0_valid, o0_data, o0_last, o1_valid} !== 35'd0) begin
            errors++;
            $display("FAIL async_reset: got v=%b d=%h l=%b v1=%b, want 0",
                     o0_valid, o0_data, o0_last, o1_valid);
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (o0_valid !== 1'b0 || o0_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_empty: got v=%b rdy=%b, want 0 1", o0_valid, o0_in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 32'hC000_3C00; in_mode = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({o0_valid, o0_data, o0_last} !== {1'b1, 32'h3F80_0000, 1'b0}) begin
            errors++;
            $display("FAIL post_reset_first: got v=%b d=%h l=%b, want 1 3f800000 0",
                     o0_valid, o0_data, o0_last);
        end
        @(negedge clk);
        checks++;
        if ({o0_valid, o0_data, o0_last} !== {1'b1, 32'hC000_0000, 1'b1}) begin
            errors++;
            $display("FAIL post_reset_second: got v=%b d=%h l=%b, want 1 c0000000 1",
                     o0_valid, o0_data, o0_last);
        end
        @(negedge clk);
        checks++;
        if (o0_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got v=%b, want 0", o0_valid);
        end
    endtask

    task automatic test_random();
        // Scoreboard entries: {data, last, nv, uf}.
        logic [34:0] q0 [$];
        logic [34:0] q1 [$];
        logic [34:0] x0, x1;
        logic [33:0] r;
        logic        acc;
        logic        exp_rdy;
        acc = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = {rand_half(), rand_half()};
                in_mode  = ($urandom_range(0, 2) == 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            exp_rdy = (q0.size() == 0) || (q0.size() == 1 && out_ready);
            checks++;
            if (o0_valid !== (q0.size() != 0) || o0_in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rand_hs c=%0d: got v=%b rdy=%b, want v=%b rdy=%b",
                         c, o0_valid, o0_in_ready, q0.size() != 0, exp_rdy);
            end
            if (q0.size() != 0) begin
                x0 = q0[0];
                x1 = q1[0];
                checks++;
                if ({o0_data, o0_last, o0_nv, o0_uf} !== x0) begin
                    errors++;
                    $display("FAIL rand_beat0 c=%0d: got %h l=%b nv=%b uf=%b, want %h l=%b nv=%b uf=%b",
                             c, o0_data, o0_last, o0_nv, o0_uf, x0[34:3], x0[2], x0[1], x0[0]);
                end
                checks++;
                if ({o1_valid, o1_data, o1_last, o1_nv, o1_uf} !== {1'b1, x1}) begin
                    errors++;
                    $display("FAIL rand_beat1 c=%0d: got v=%b %h l=%b nv=%b uf=%b, want %h l=%b nv=%b uf=%b",
                             c, o1_valid, o1_data, o1_last, o1_nv, o1_uf,
                             x1[34:3], x1[2], x1[1], x1[0]);
                end
                if (out_ready) begin
                    void'(q0.pop_front());
                    void'(q1.pop_front());
                end
            end
            acc = in_valid && o0_in_ready;
            if (acc) begin
                if (in_mode) begin
                    q0.push_back({in_data, 3'b100});
                    q1.push_back({in_data, 3'b100});
                end else begin
                    r = ref_half(in_data[15:0], 1'b0);
                    q0.push_back({r[33:2], 1'b0, r[1:0]});
                    r = ref_half(in_data[31:16], 1'b0);
                    q0.push_back({r[33:2], 1'b1, r[1:0]});
                    r = ref_half(in_data[31:16], 1'b1);
                    q1.push_back({r[33:2], 1'b0, r[1:0]});
                    r = ref_half(in_data[15:0], 1'b1);
                    q1.push_back({r[33:2], 1'b1, r[1:0]});
                end
            end
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (o0_valid !== 1'b0 || o1_valid !== 1'b0) begin
            errors++;
            $display("FAIL rand_drain: got v0=%b v1=%b, want 0", o0_valid, o1_valid);
        end
    endtask

    initial begin
        test_reset();
        test_packed();
        test_stall();
        test_back_to_back();
        test_reset_mid_word();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
